// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin owner selection for one shared resource with hold limit and turnaround gap
module rr_resource_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout
);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] next_ptr;
    logic [CW-1:0]   cnt;
    logic            found;
    logic            owner_req;
    logic            release_now;

    assign owner_req   = req[grant_id];
    assign release_now = !owner_req || cnt == CW'(MAX_HOLD - 1);
    assign next_ptr    = grant_id == ID_W'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    // First active request scanning upward from ptr with wrap-around
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Owner FSM: arbitrate in IDLE, hold in BUSY until release or hold limit, one GAP cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    state    <= BUSY;
                    grant    <= NUM_REQ'(1) << pick;
                    grant_id <= pick;
                    busy     <= 1'b1;
                    cnt      <= '0;
                end
                BUSY: if (release_now) begin
                    state    <= GAP;
                    grant    <= '0;
                    grant_id <= '0;
                    busy     <= 1'b0;
                    ptr      <= next_ptr;
                    timeout  <= owner_req;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: directed checks of reset, rotation, hold limit, late requests and async reset
module tb_rr_resource_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b1111;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;
    int passed = 0;
    int total  = 0;

    rr_resource_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_HOLD(8)) dut (
        .clock(clock), .reset(reset), .req(req),
        .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Full-length grant (8 cycles), timeout pulse, then second gap cycle
    task automatic hold(input logic [3:0] g, input logic [1:0] id);
        for (int k = 0; k < 8; k++) begin
            chk("hold_grant", 32'(grant), 32'(g));
            chk("hold_id", 32'(grant_id), 32'(id));
            chk("hold_busy", 32'(busy), 1);
            @(negedge clock);
        end
        chk("to_pulse", 32'(timeout), 1);
        chk("to_grant", 32'(grant), 0);
        @(negedge clock);
        chk("gap_timeout", 32'(timeout), 0);
        chk("gap_grant", 32'(grant), 0);
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_id", 32'(grant_id), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_id", 32'(grant_id), 0);
        chk("first_busy", 32'(busy), 1);
        req = 4'b0000;
        @(negedge clock);
        chk("rel_grant", 32'(grant), 0);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_timeout", 32'(timeout), 0);
        @(negedge clock);
        req = 4'b0100;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk("single_grant", 32'(grant), 32'h4);
            chk("single_id", 32'(grant_id), 2);
            if (k == 2) req = 4'b0000;
            @(negedge clock);
        end
        chk("single_rel", 32'(grant), 0);
        chk("single_to", 32'(timeout), 0);
        req = 4'b1111;
        @(negedge clock);
        chk("single_gap", 32'(grant), 0);
        @(negedge clock);
        hold(4'b1000, 2'd3);
        hold(4'b0001, 2'd0);
        hold(4'b0010, 2'd1);
        hold(4'b0100, 2'd2);
        chk("wrap_grant", 32'(grant), 32'h8);
        req = 4'b0010;
        @(negedge clock);
        chk("norm_rel_to", 32'(timeout), 0);
        chk("norm_rel_grant", 32'(grant), 0);
        @(negedge clock);
        chk("norm_gap", 32'(grant), 0);
        @(negedge clock);
        hold(4'b0010, 2'd1);
        chk("regrant", 32'(grant), 32'h2);
        req = 4'b0000;
        @(negedge clock);
        req = 4'b0100;
        @(negedge clock);
        @(negedge clock);
        chk("late_own", 32'(grant), 32'h4);
        req = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("late_hold", 32'(grant), 32'h4);
        end
        req = 4'b0001;
        @(negedge clock);
        chk("late_rel", 32'(grant), 0);
        @(negedge clock);
        chk("late_gap", 32'(grant), 0);
        @(negedge clock);
        chk("late_next", 32'(grant), 32'h1);
        chk("late_next_id", 32'(grant_id), 0);
        req = 4'b1000;
        repeat (3) @(negedge clock);
        chk("pre_rst_grant", 32'(grant), 32'h8);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_id", 32'(grant_id), 0);
        #1 reset = 1'b1;
        req = 4'b1111;
        @(negedge clock);
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_id", 32'(grant_id), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
